// File: rtl/core_pkg.sv
// Shared core types: forwarding selects, hazard FSM states, scoreboard slot layout.
package core_pkg;

  typedef enum logic [2:0] {
    NO_FORWARD,
    FWD_EX_TO_ID,
    FWD_MEM_ALU_RES_TO_ID,
    FWD_MEM_RDATA_TO_ID,
    FWD_WB_ALU_RES_TO_ID,
    FWD_WB_RDATA_TO_ID
  } forward_t;

  typedef enum logic {
    HZ_RUN,
    HZ_MC_WAIT
  } hazard_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_alu;
    logic       is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // A slot only produces a value worth forwarding if it really writes a non-x0 register.
  function automatic logic sb_writes(input sb_entry_t e);
    return e.valid && (e.is_alu || e.is_load) && (e.rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID-stage <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface hazard_controller_if;
  import core_pkg::*;

  logic [4:0] rs1_addr_id_i;
  logic [4:0] rs2_addr_id_i;
  logic [4:0] rd_addr_id_i;
  logic       reg_alu_wen_id_i;
  logic       reg_mem_wen_id_i;
  logic       decode_ok_id_i;
  logic       jump_id_i;
  logic       branch_taken_ex_i;
  logic       mc_busy_ex_i;
  logic       stall_if_o;
  logic       stall_id_o;
  logic       stall_ex_o;
  logic       flush_id_o;
  logic       flush_ex_o;
  forward_t   fwd_op1_id_o;
  forward_t   fwd_op2_id_o;

  modport master (
    output rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i, reg_alu_wen_id_i, reg_mem_wen_id_i,
           decode_ok_id_i, jump_id_i, branch_taken_ex_i, mc_busy_ex_i,
    input  stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, fwd_op1_id_o, fwd_op2_id_o
  );

  modport slave (
    input  rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i, reg_alu_wen_id_i, reg_mem_wen_id_i,
           decode_ok_id_i, jump_id_i, branch_taken_ex_i, mc_busy_ex_i,
    output stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, fwd_op1_id_o, fwd_op2_id_o
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority selector: nearest writing slot wins (EX > MEM > WB).
module hazard_fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  input  sb_entry_t  wb_i,
  output forward_t   fwd_o,
  output logic       load_hit_o
);

  always_comb begin
    fwd_o      = NO_FORWARD;
    load_hit_o = 1'b0;
    if (rs_addr_i != 5'd0) begin
      if (sb_writes(ex_i) && (ex_i.rd == rs_addr_i)) begin
        // Load data is not available yet: the caller must stall instead of forwarding.
        if (ex_i.is_load) load_hit_o = 1'b1;
        else              fwd_o      = FWD_EX_TO_ID;
      end else if (sb_writes(mem_i) && (mem_i.rd == rs_addr_i)) begin
        fwd_o = mem_i.is_load ? FWD_MEM_RDATA_TO_ID : FWD_MEM_ALU_RES_TO_ID;
      end else if (sb_writes(wb_i) && (wb_i.rd == rs_addr_i)) begin
        fwd_o = wb_i.is_load ? FWD_WB_RDATA_TO_ID : FWD_WB_ALU_RES_TO_ID;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller: scoreboard of EX/MEM/WB writers, forwarding, stalls, flushes.
// Optional RISCX_HAZARD_PERF_EN adds load-use / multi-cycle / flush event counters.
module hazard_controller
  import core_pkg::*;
#(
  parameter int ISA_M = 0,
  parameter int ISA_C = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_controller_if.slave hz
`ifdef RISCX_HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_load_use_o,
  output logic [31:0]        perf_mc_stall_o,
  output logic [31:0]        perf_flush_o
`endif
);

  if (ISA_M < 0 || ISA_M > 1 || ISA_C < 0 || ISA_C > 1) begin : g_param_check
    $error("hazard_controller: ISA_M and ISA_C must be 0 or 1");
  end

  localparam bit MC_EN = (ISA_M != 0);

  sb_entry_t     sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d, sb_wb_q, sb_wb_d;
  hazard_state_t state_q, state_d;
  sb_entry_t     id_entry;
  forward_t      fwd1, fwd2;
  logic          hit1, hit2;
  logic          mc_req, mc_stall, load_use, lu_stall;
  logic          stall_if, stall_id, stall_ex, flush_id, flush_ex;

  hazard_fwd_sel u_fwd_op1 (
    .rs_addr_i (hz.rs1_addr_id_i),
    .ex_i      (sb_ex_q),
    .mem_i     (sb_mem_q),
    .wb_i      (sb_wb_q),
    .fwd_o     (fwd1),
    .load_hit_o(hit1)
  );

  hazard_fwd_sel u_fwd_op2 (
    .rs_addr_i (hz.rs2_addr_id_i),
    .ex_i      (sb_ex_q),
    .mem_i     (sb_mem_q),
    .wb_i      (sb_wb_q),
    .fwd_o     (fwd2),
    .load_hit_o(hit2)
  );

  assign mc_req   = MC_EN && hz.mc_busy_ex_i;
  assign load_use = hz.decode_ok_id_i && (hit1 || hit2);

  // Stall is raised in the first busy cycle and dropped in the first idle one.
  always_comb begin
    state_d  = state_q;
    mc_stall = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mc_req) begin
          state_d  = HZ_MC_WAIT;
          mc_stall = 1'b1;
        end
      end
      HZ_MC_WAIT: begin
        if (mc_req) mc_stall = 1'b1;
        else        state_d  = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Priority: multi-cycle wait, then taken branch, then load-use / jump.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    lu_stall = 1'b0;
    if (!rst_i) begin
      if (mc_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (hz.branch_taken_ex_i) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        lu_stall = 1'b1;
      end else if (hz.jump_id_i) begin
        flush_id = 1'b1;
      end
    end
  end

  assign hz.stall_if_o   = stall_if;
  assign hz.stall_id_o   = stall_id;
  assign hz.stall_ex_o   = stall_ex;
  assign hz.flush_id_o   = flush_id;
  assign hz.flush_ex_o   = flush_ex;
  assign hz.fwd_op1_id_o = rst_i ? NO_FORWARD : fwd1;
  assign hz.fwd_op2_id_o = rst_i ? NO_FORWARD : fwd2;

  always_comb begin
    id_entry.valid   = 1'b1;
    id_entry.rd      = hz.rd_addr_id_i;
    id_entry.is_alu  = hz.reg_alu_wen_id_i;
    id_entry.is_load = hz.reg_mem_wen_id_i;
  end

  always_comb begin
    sb_ex_d  = SB_BUBBLE;
    sb_mem_d = sb_ex_q;
    sb_wb_d  = sb_mem_q;
    if (stall_ex) begin
      sb_ex_d  = sb_ex_q;
      sb_mem_d = SB_BUBBLE;
    end else if (hz.decode_ok_id_i && !stall_id && !flush_ex) begin
      sb_ex_d = id_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_ex_q  <= SB_BUBBLE;
      sb_mem_q <= SB_BUBBLE;
      sb_wb_q  <= SB_BUBBLE;
      state_q  <= HZ_RUN;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
      state_q  <= state_d;
    end
  end

`ifdef RISCX_HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_mc_q, perf_fl_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_q <= '0;
      perf_mc_q <= '0;
      perf_fl_q <= '0;
    end else begin
      if (lu_stall)                perf_lu_q <= perf_lu_q + 32'd1;
      if (state_q == HZ_MC_WAIT)   perf_mc_q <= perf_mc_q + 32'd1;
      if (flush_ex)                perf_fl_q <= perf_fl_q + 32'd1;
    end
  end

  assign perf_load_use_o = perf_lu_q;
  assign perf_mc_stall_o = perf_mc_q;
  assign perf_flush_o    = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench: driver queues expected outputs per cycle, monitor checks on negedge.
module tb_hazard_controller;
  import core_pkg::*;

  typedef struct {
    string    name;
    logic     sif, sid, sex, fid, fex;
    forward_t f1, f2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  hazard_controller_if hz_if ();

`ifdef RISCX_HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_mc, perf_fl;
`endif

  hazard_controller #(.ISA_M(1), .ISA_C(0)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz_if.slave)
`ifdef RISCX_HAZARD_PERF_EN
    ,
    .perf_load_use_o(perf_lu),
    .perf_mc_stall_o(perf_mc),
    .perf_flush_o   (perf_fl)
`endif
  );

  always #5 clk = ~clk;

  task automatic v(input string name,
                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                   input logic alu, input logic ld, input logic ok, input logic jmp,
                   input logic br, input logic busy, input logic rs,
                   input logic sif, input logic sid, input logic sex,
                   input logic fid, input logic fex,
                   input forward_t f1, input forward_t f2);
    exp_t e;
    @(posedge clk);
    #1;
    hz_if.rs1_addr_id_i     = rs1;
    hz_if.rs2_addr_id_i     = rs2;
    hz_if.rd_addr_id_i      = rd;
    hz_if.reg_alu_wen_id_i  = alu;
    hz_if.reg_mem_wen_id_i  = ld;
    hz_if.decode_ok_id_i    = ok;
    hz_if.jump_id_i         = jmp;
    hz_if.branch_taken_ex_i = br;
    hz_if.mc_busy_ex_i      = busy;
    rst                     = rs;
    e.name = name;
    e.sif = sif; e.sid = sid; e.sex = sex; e.fid = fid; e.fex = fex;
    e.f1 = f1; e.f2 = f2;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (hz_if.stall_if_o !== e.sif || hz_if.stall_id_o !== e.sid ||
            hz_if.stall_ex_o !== e.sex || hz_if.flush_id_o !== e.fid ||
            hz_if.flush_ex_o !== e.fex || hz_if.fwd_op1_id_o !== e.f1 ||
            hz_if.fwd_op2_id_o !== e.f2) begin
          n_err++;
          $display("FAIL %s: stall if/id/ex flush id/ex fwd1 fwd2 got %b%b%b %b%b %s %s, expected %b%b%b %b%b %s %s",
                   e.name, hz_if.stall_if_o, hz_if.stall_id_o, hz_if.stall_ex_o,
                   hz_if.flush_id_o, hz_if.flush_ex_o,
                   hz_if.fwd_op1_id_o.name(), hz_if.fwd_op2_id_o.name(),
                   e.sif, e.sid, e.sex, e.fid, e.fex, e.f1.name(), e.f2.name());
        end
      end
    end
  end

  initial begin : driver
    hz_if.rs1_addr_id_i     = '0;
    hz_if.rs2_addr_id_i     = '0;
    hz_if.rd_addr_id_i      = '0;
    hz_if.reg_alu_wen_id_i  = 1'b0;
    hz_if.reg_mem_wen_id_i  = 1'b0;
    hz_if.decode_ok_id_i    = 1'b0;
    hz_if.jump_id_i         = 1'b0;
    hz_if.branch_taken_ex_i = 1'b0;
    hz_if.mc_busy_ex_i      = 1'b0;
    repeat (2) @(posedge clk);

    //  name               rs1 rs2 rd  alu ld ok jmp br bsy rst  sif sid sex fid fex  fwd1 fwd2
    v("reset",            0,  0,  0,  0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("addi_x5",          0,  0,  5,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("ex_fwd_x5",        5,  0,  6,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_EX_TO_ID, NO_FORWARD);
    v("mem_alu_x5",       5,  0,  7,  0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_MEM_ALU_RES_TO_ID, NO_FORWARD);
    v("load_use_x7",      7,  7,  8,  1, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("load_use_resolve", 7,  7,  8,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_MEM_RDATA_TO_ID, FWD_MEM_RDATA_TO_ID);
    v("wb_load_ex_alu",   7,  8,  0,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_WB_RDATA_TO_ID, FWD_EX_TO_ID);
    v("mem_alu_x8",       0,  8,  0,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, FWD_MEM_ALU_RES_TO_ID);
    v("wb_alu_x8",        0,  8,  0,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, FWD_WB_ALU_RES_TO_ID);
    v("x0_all_slots",     0,  0,  9,  0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("addi_x1",          0,  0,  1,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("mem_load_x9",      9,  1,  9,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_MEM_RDATA_TO_ID, FWD_EX_TO_ID);
    v("nearest_x9",       9,  9,  2,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, FWD_EX_TO_ID, FWD_EX_TO_ID);
    v("lw_x10",           0,  0, 10,  0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("branch_over_lu",  10,  9, 11,  1, 0, 1, 0, 1, 0, 0,   0, 0, 0, 1, 1, NO_FORWARD, FWD_WB_ALU_RES_TO_ID);
    v("jump_after_flush",10,  0,  3,  1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, FWD_MEM_RDATA_TO_ID, NO_FORWARD);
    v("branch_and_jump",  3, 10,  0,  1, 0, 1, 1, 1, 0, 0,   0, 0, 0, 1, 1, FWD_EX_TO_ID, FWD_WB_RDATA_TO_ID);
    v("mc_busy_1",        3,  0, 12,  1, 0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 0, FWD_MEM_ALU_RES_TO_ID, NO_FORWARD);
    v("mc_busy_2",        3,  0, 12,  1, 0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 0, FWD_WB_ALU_RES_TO_ID, NO_FORWARD);
    for (int i = 3; i <= 5; i++)
      v($sformatf("mc_busy_%0d", i),
                          3,  0, 12,  1, 0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 0, NO_FORWARD, NO_FORWARD);
    v("mc_release",       3,  0, 12,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("mc_jump_held",    12,  0,  0,  1, 0, 1, 1, 0, 1, 0,   1, 1, 1, 0, 0, FWD_EX_TO_ID, NO_FORWARD);
    v("rst_mid_wait",    12,  0,  0,  1, 0, 1, 1, 0, 1, 1,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("after_rst",       12,  0,  0,  1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("lw_x13",           0,  0, 13,  0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);
    v("lu_not_decoded",  13,  0,  4,  1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, NO_FORWARD, NO_FORWARD);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
